// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between I-fetch and D load/store, counting fixed latency.
// Define ARB_RR_EN for round-robin tie breaking; otherwise D always beats I.
module mem_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic win_d, own_d, own_d_n;
   logic i_ack_n, d_ack_n, mem_en_n, mem_we_n;
   logic [AW-1:0] mem_addr_n;
   logic [DW-1:0] mem_wdata_n, i_rdata_n, d_rdata_n;
`ifdef ARB_RR_EN
   logic last_d;
   assign win_d = d_req & (~i_req | ~last_d);
   always_ff @(posedge clk)
      if (reset) last_d <= 1'b0;
      else if (state == IDLE && (i_req | d_req)) last_d <= win_d;
`else
   assign win_d = d_req;
`endif
   assign busy = state != IDLE;
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      own_d_n     = own_d;
      i_ack_n     = 1'b0;
      d_ack_n     = 1'b0;
      mem_en_n    = 1'b0;
      mem_we_n    = mem_we;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      i_rdata_n   = i_rdata;
      d_rdata_n   = d_rdata;
      case (state)
         IDLE: if (i_req | d_req) begin
            state_n     = WAIT;
            cnt_n       = 4'(MEM_LAT);
            own_d_n     = win_d;
            mem_en_n    = 1'b1;
            mem_addr_n  = win_d ? d_addr : i_addr;
            mem_we_n    = win_d & d_we;
            mem_wdata_n = win_d ? d_wdata : mem_wdata;
         end
         // count starts once memory has sampled mem_en, so data lands MEM_LAT edges later
         WAIT: begin
            cnt_n = mem_en ? cnt : cnt - 4'd1;
            if (!mem_en && cnt == 4'd1) begin
               state_n   = RESP;
               i_ack_n   = ~own_d;
               d_ack_n   = own_d;
               i_rdata_n = (!own_d && !mem_we) ? mem_rdata : i_rdata;
               d_rdata_n = (own_d && !mem_we) ? mem_rdata : d_rdata;
            end
         end
         RESP: begin
            state_n  = IDLE;
            mem_we_n = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         own_d     <= 1'b0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         own_d     <= own_d_n;
         i_ack     <= i_ack_n;
         d_ack     <= d_ack_n;
         mem_en    <= mem_en_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         i_rdata   <= i_rdata_n;
         d_rdata   <= d_rdata_n;
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors and corner sequences for mem_arbiter with MEM_LAT=2.
module tb_mem_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic i_ack, d_ack, mem_en, mem_we, busy;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [15:0] st1 = '0, st2 = '0;
   int checks = 0, errors = 0;

   typedef struct {
      logic        i_req;
      logic [15:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      logic        exp_d;
      logic [15:0] exp_addr;
      logic        exp_we;
      logic [15:0] exp_wdata;
      logic [15:0] exp_i_rdata;
      logic [15:0] exp_d_rdata;
   } vec_t;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(2)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // memory model: data for an access sampled at edge e is visible at edge e+2
   always @(posedge clk) begin
      if (mem_en) st1 <= mem_addr ^ 16'hA5A5;
      st2 <= st1;
   end
   assign mem_rdata = st2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic any_out();
      return |{i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy};
   endfunction

   task automatic do_access(input string tag, input vec_t v);
      int en_at, ack_at;
      logic got_i, got_d, w;
      logic [15:0] a, wd;
      en_at = -1; ack_at = -1; got_i = 1'b0; got_d = 1'b0; w = 1'bx; a = 'x; wd = 'x;
      i_req = v.i_req; i_addr = v.i_addr;
      d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
      for (int e = 0; e < 12 && ack_at < 0; e++) begin
         tick();
         if (mem_en && en_at < 0) begin
            en_at = e; a = mem_addr; w = mem_we; wd = mem_wdata;
         end
         if (i_ack || d_ack) begin
            ack_at = e; got_i = i_ack; got_d = d_ack;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      check({tag, "_en_edge"}, en_at, 0);
      check({tag, "_ack_edge"}, ack_at, 3);
      check({tag, "_ack_which"}, {got_i, got_d}, {~v.exp_d, v.exp_d});
      check({tag, "_addr"}, a, v.exp_addr);
      check({tag, "_we"}, w, v.exp_we);
      if (v.exp_we) check({tag, "_wdata"}, wd, v.exp_wdata);
      check({tag, "_i_rdata"}, i_rdata, v.exp_i_rdata);
      check({tag, "_d_rdata"}, d_rdata, v.exp_d_rdata);
      tick();
      check({tag, "_idle"}, {i_ack, d_ack, busy, mem_we}, 4'b0);
   endtask

   initial begin
      vec_t vecs[6];
      vec_t ld;
      logic seen;
      logic [1:0] got;
      logic [1:0] exp_g [3];
      logic [9:0] en_pat, ack_pat, busy_pat;
      vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'hA5B5, 16'h0000};
      vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b1, 16'h0020, 1'b1, 16'hBEEF, 16'hA5B5, 16'h0000};
      vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'h0000, 16'hA5B5, 16'hA595};
      vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b1, 16'h0040, 1'b1, 16'h1234, 16'hA5B5, 16'hA595};
      vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'h5A5A, 16'hA595};
      vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h5A5A, 16'hA5A5};
`ifdef ARB_RR_EN
      exp_g = '{2'd1, 2'd0, 2'd1};
`else
      exp_g = '{2'd1, 2'd1, 2'd1};
`endif
      // reset held two cycles with requests present
      reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 16'h1111; d_addr = 16'h2222;
      for (int c = 0; c < 2; c++) begin
         tick();
         check($sformatf("reset_outputs_%0d", c), any_out(), 1'b0);
      end
      i_req = 1'b0; d_req = 1'b0; reset = 1'b0;
      tick();
      check("post_reset_idle", any_out(), 1'b0);

      for (int n = 0; n < 6; n++) do_access($sformatf("vec%0d", n), vecs[n]);

      // simultaneous requests, each re-raised after its ack
      do_reset();
      i_addr = 16'h0100; d_addr = 16'h0200; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
      for (int g = 0; g < 3; g++) begin
         got = 2'd2;
         for (int e = 0; e < 12; e++) begin
            tick();
            if (i_ack || d_ack) begin
               got = d_ack ? 2'd1 : 2'd0;
               break;
            end
         end
         check($sformatf("tie_grant%0d", g), got, exp_g[g]);
         if (g == 2 || got == 2'd2) begin
            i_req = 1'b0; d_req = 1'b0;
         end else if (got == 2'd1) d_req = 1'b0;
         else i_req = 1'b0;
         tick();
         if (g < 2) begin
            i_req = 1'b1; d_req = 1'b1;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      for (int e = 0; e < 8; e++) tick();

      // reset pulsed while a load waits on memory
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; d_req = 1'b0;
      check("rst_mid_outputs", any_out(), 1'b0);
      seen = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         seen |= i_ack | d_ack | mem_en;
      end
      check("rst_mid_no_ack", seen, 1'b0);
      ld = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'h0000, 16'h0000, 16'hA595};
      do_access("reload", ld);

      // back-to-back fetches with request held
      do_reset();
      i_req = 1'b1; i_addr = 16'h0050;
      for (int e = 0; e < 10; e++) begin
         tick();
         en_pat[e] = mem_en; ack_pat[e] = i_ack; busy_pat[e] = busy;
      end
      i_req = 1'b0;
      check("b2b_mem_en", en_pat, 10'b0000100001);
      check("b2b_i_ack", ack_pat, 10'b0100001000);
      check("b2b_busy", busy_pat, 10'b0111101111);
      check("b2b_i_rdata", i_rdata, 16'hA5F5);
      tick();
      check("b2b_idle", {busy, mem_en}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
